add64_seq: RTL and testbench

ADD64_SEQ -- requirements
Module: add64_seq

---
 rtl/add64_seq.sv | 169 ++++++++++++++++
 tb/tb_add64_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/add64_seq.sv
// add64_seq: 64-bit adder built from one external 32-bit adder, used twice.
// A captured request is summed as a low half (LO) and then a high half (HI),
// with the low-half carry fed into the high half. The result is held in DONE
// until the consumer accepts it.
// Optional build macro ADD64_SUB_EN adds an op_sub input. With op_sub=1 the
// block computes in_a - in_b as in_a + ~in_b + 1, and out_co is NOT borrow.
module add64_seq #(
  parameter int ZERO_IDLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  input  logic        in_ci,
`ifdef ADD64_SUB_EN
  input  logic        op_sub,
`endif
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_ci,
  input  logic [31:0] add_s,
  input  logic        add_co,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_sum,
  output logic        out_co
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state_reg, state_next;
  logic [63:0] a_reg;
  logic [63:0] b_reg;
  logic        ci_reg;
  logic        carry_reg;
  logic [63:0] sum_reg;
  logic        co_reg;
`ifdef ADD64_SUB_EN
  logic        sub_reg;
`endif

  // Adder operand values for the current phase; zero outside LO/HI.
  logic [31:0] drv_a, drv_b;
  logic        drv_ci;
  logic        drv_active;

  // State register; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: LO and HI each last exactly one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = LO;
      LO:      state_next = HI;
      HI:      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_sum   = sum_reg;
  assign out_co    = co_reg;

  // Operand capture and per-half result collection from the external adder.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      ci_reg    <= 1'b0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      co_reg    <= 1'b0;
`ifdef ADD64_SUB_EN
      sub_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= in_a;
            b_reg  <= in_b;
            ci_reg <= in_ci;
`ifdef ADD64_SUB_EN
            sub_reg <= op_sub;
`endif
          end
        end
        LO: begin
          sum_reg[31:0] <= add_s;
          carry_reg     <= add_co;
        end
        HI: begin
          sum_reg[63:32] <= add_s;
          co_reg         <= add_co;
        end
        default: ;
      endcase
    end
  end

  // Select the half-operands for the adder according to the phase.
  always_comb begin
    drv_a      = '0;
    drv_b      = '0;
    drv_ci     = 1'b0;
    drv_active = 1'b0;
    case (state_reg)
      LO: begin
        drv_active = 1'b1;
        drv_a      = a_reg[31:0];
`ifdef ADD64_SUB_EN
        // Subtraction: invert B and force the +1 in through the low carry-in.
        drv_b  = sub_reg ? ~b_reg[31:0] : b_reg[31:0];
        drv_ci = sub_reg ? 1'b1 : ci_reg;
`else
        drv_b  = b_reg[31:0];
        drv_ci = ci_reg;
`endif
      end
      HI: begin
        drv_active = 1'b1;
        drv_a      = a_reg[63:32];
`ifdef ADD64_SUB_EN
        drv_b = sub_reg ? ~b_reg[63:32] : b_reg[63:32];
`else
        drv_b = b_reg[63:32];
`endif
        drv_ci = carry_reg;
      end
      default: ;
    endcase
  end

  generate
    if (ZERO_IDLE != 0) begin : g_zero_idle
      // Adder inputs are quiet (zero) whenever it is not in use.
      assign add_a  = drv_a;
      assign add_b  = drv_b;
      assign add_ci = drv_ci;
    end else begin : g_hold_idle
      logic [31:0] hold_a_reg, hold_b_reg;
      logic        hold_ci_reg;
      // Remember the last operands so the adder inputs do not toggle when idle.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hold_a_reg  <= '0;
          hold_b_reg  <= '0;
          hold_ci_reg <= 1'b0;
        end else if (drv_active) begin
          hold_a_reg  <= drv_a;
          hold_b_reg  <= drv_b;
          hold_ci_reg <= drv_ci;
        end
      end
      assign add_a  = drv_active ? drv_a  : hold_a_reg;
      assign add_b  = drv_active ? drv_b  : hold_b_reg;
      assign add_ci = drv_active ? drv_ci : hold_ci_reg;
    end
  endgenerate

endmodule

// File: tb/tb_add64_seq.sv
// Directed and random bench for add64_seq with a behavioural 32-bit adder
// closing the loop on add_a/add_b/add_ci -> add_s/add_co.
module tb_add64_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a, in_b;
  logic        in_ci;
`ifdef ADD64_SUB_EN
  logic        op_sub;
`endif
  logic [31:0] add_a, add_b, add_s;
  logic        add_ci, add_co;
  logic        out_valid, out_ready;
  logic [63:0] out_sum;
  logic        out_co;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // External 32-bit adder.
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};

  add64_seq #(.ZERO_IDLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
`ifdef ADD64_SUB_EN
    .op_sub(op_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_co(out_co)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One directed request with out_ready=1; expected values supplied by caller.
  task automatic run_req(input string name, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic [63:0] exp_sum, input logic exp_co,
                         input logic exp_hi_ci);
    in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1; out_ready = 1'b1;
    tick();  // accepted, now LO
    chk({name, " lo in_ready"}, in_ready, 0);
    chk({name, " lo out_valid"}, out_valid, 0);
    chk({name, " lo add_a"}, add_a, a[31:0]);
    chk({name, " lo add_ci"}, add_ci, ci);
    // Post-capture input changes and a stray in_valid must be ignored.
    in_a = ~a; in_b = ~b; in_ci = ~ci;
    tick();  // HI
    chk({name, " hi add_a"}, add_a, a[63:32]);
    chk({name, " hi add_b"}, add_b, b[63:32]);
    chk({name, " hi add_ci"}, add_ci, exp_hi_ci);
    chk({name, " hi out_valid"}, out_valid, 0);
    in_valid = 1'b0;
    tick();  // DONE: third cycle after the accept edge
    chk({name, " out_valid"}, out_valid, 1);
    chk({name, " out_sum"}, out_sum, exp_sum);
    chk({name, " out_co"}, out_co, exp_co);
    tick();  // consumed, back to IDLE
    chk({name, " idle out_valid"}, out_valid, 0);
    chk({name, " idle in_ready"}, in_ready, 1);
    chk({name, " idle sum kept"}, out_sum, exp_sum);
    chk({name, " idle add_a"}, add_a, 0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rci;
    logic [64:0] ref_val;
    int          cnt;

    // Reset with in_valid and out_ready also high: reset must win.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_a = 64'h1234; in_b = 64'h5678; in_ci = 1'b1;
`ifdef ADD64_SUB_EN
    op_sub = 1'b0;
`endif
    tick();
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_sum", out_sum, 0);
    chk("rst out_co", out_co, 0);
    chk("rst add_a", add_a, 0);
    chk("rst add_b", add_b, 0);
    chk("rst add_ci", add_ci, 0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post-rst in_ready", in_ready, 1);

    // Carry crossing from low half into high half.
    run_req("cross", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
            64'h0000_0001_0000_0000, 1'b0, 1'b1);
    // All ones plus all ones plus carry-in.
    run_req("allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    // Mixed pattern, low carry set, no final carry.
    run_req("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
            64'h2222_2222_2222_2211, 1'b0, 1'b1);
    // Only the top bits overflow.
    run_req("topovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
            64'h0, 1'b1, 1'b0);

    // Backpressure: 5+7 held in DONE for 10 cycles.
    in_a = 64'd5; in_b = 64'd7; in_ci = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    tick(); tick(); tick();
    in_a = 64'd100; in_b = 64'd200;  // in_valid left high: must be ignored
    for (int i = 0; i < 10; i++) begin
      chk("bp out_valid", out_valid, 1);
      chk("bp out_sum", out_sum, 64'd12);
      chk("bp in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp release out_valid", out_valid, 0);
    chk("bp release in_ready", in_ready, 1);

    // Reset during HI of 1+1 aborts the request.
    in_a = 64'd1; in_b = 64'd1; in_ci = 1'b0; in_valid = 1'b1;
    tick();  // LO
    in_valid = 1'b0;
    tick();  // HI
    rst_n = 1'b0;
    tick();
    chk("abort out_valid", out_valid, 0);
    chk("abort out_sum", out_sum, 0);
    chk("abort in_ready", in_ready, 1);
    chk("abort add_a", add_a, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("abort no result", out_valid, 0);

`ifdef ADD64_SUB_EN
    // 3 - 5 wraps to -2 with a borrow (out_co = 0).
    in_a = 64'd3; in_b = 64'd5; in_ci = 1'b0; op_sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("sub out_valid", out_valid, 1);
    chk("sub out_sum", out_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub out_co", out_co, 0);
    tick();
    op_sub = 1'b0;
`endif

    // Random requests with random gaps and random backpressure.
    for (int r = 0; r < 100; r++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rci = 1'($urandom_range(0, 1));
      if (r % 10 == 0) rb = ~ra;  // exercise full carry propagation
      ref_val = {1'b0, ra} + {1'b0, rb} + {64'd0, rci};
      in_valid = 1'b0; out_ready = 1'b0;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      cnt = 0;
      while (!in_ready && cnt < 10) begin tick(); cnt++; end
      chk("rand in_ready timeout", in_ready, 1);
      in_a = ra; in_b = rb; in_ci = rci; in_valid = 1'b1;
      tick();
      in_valid = 1'($urandom_range(0, 1));
      in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      cnt = 0;
      while (!out_valid && cnt < 10) begin tick(); cnt++; end
      chk("rand out_valid timeout", out_valid, 1);
      in_valid = 1'b0;
      chk("rand out_sum", out_sum, ref_val[63:0]);
      chk("rand out_co", out_co, ref_val[64]);
      cnt = 0;
      do begin
        out_ready = (cnt >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
        if (!out_ready) chk("rand hold sum", out_sum, ref_val[63:0]);
        tick();
        cnt++;
      end while (!out_ready);
      chk("rand consumed", out_valid, 0);
      $display("req %0d: a=%h b=%h ci=%0d sum=%h co=%0d", r, ra, rb, rci, out_sum, out_co);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Overall time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
